hazard_unit: RTL and testbench

HAZARD_UNIT -- requirements
Module: hazard_unit

---
 rtl/hazard_unit_pkg.sv | 9 +
 rtl/hazard_cnt16.sv | 14 +
 rtl/hazard_unit.sv | 80 ++++++++
 tb/tb_hazard_unit.sv | 147 ++++++++++++++
 4 files changed

// File: rtl/hazard_unit_pkg.sv
// hazard_unit_pkg: shared CPU constants, state encoding and counter helper for the hazard unit
package hazard_unit_pkg;
  localparam int REG_W = 6;
  localparam logic [15:0] CNT_MAX = 16'hFFFF;
  typedef enum logic {RUN = 1'b0, STALL = 1'b1} hz_state_e;
  function automatic logic [15:0] sat_inc(input logic [15:0] v);
    return v == CNT_MAX ? v : v + 16'd1;
  endfunction
endpackage

// File: rtl/hazard_cnt16.sv
// hazard_cnt16: 16-bit saturating event counter with synchronous clear over increment
module hazard_cnt16
  import hazard_unit_pkg::*;
(
  input  logic        clock,
  input  logic        reset_n,
  input  logic        clr,
  input  logic        inc,
  output logic [15:0] count
);
  always_ff @(posedge clock or negedge reset_n)
    if (!reset_n) count <= '0;
    else count <= clr ? '0 : inc ? sat_inc(count) : count;
endmodule

// File: rtl/hazard_unit.sv
// hazard_unit: load-use stall and branch/jump flush control with stall/flush event counters
module hazard_unit
  import hazard_unit_pkg::*;
#(
  parameter int LOAD_LAT = 1
) (
  input  logic             clock,
  input  logic             reset_n,
  input  logic [REG_W-1:0] id_rs,
  input  logic [REG_W-1:0] id_rt,
  input  logic             id_uses_rs,
  input  logic             id_uses_rt,
  input  logic [REG_W-1:0] ex_rd,
  input  logic             ex_memr,
  input  logic             ex_regw,
  input  logic             ex_brz,
  input  logic             ex_brn,
  input  logic             ex_j,
  input  logic             ex_zero,
  input  logic             ex_neg,
  input  logic             cnt_clr,
  output logic             pc_write,
  output logic             if_id_write,
  output logic             if_id_flush,
  output logic             id_ex_flush,
  output logic             pc_sel_branch,
  output logic [15:0]      stall_cycles,
  output logic [15:0]      flush_events
);
  localparam logic [1:0] LEFT_INIT = 2'(LOAD_LAT - 1);
  hz_state_e  state, state_nx;
  logic [1:0] stall_left, left_nx;
  logic       branch_taken, load_use, flush_now, stall_now;
  assign branch_taken = (ex_brz & ex_zero) | (ex_brn & ex_neg) | ex_j;
  assign load_use = ex_memr & ex_regw &
                    ((id_uses_rs & (id_rs == ex_rd)) | (id_uses_rt & (id_rt == ex_rd)));
  // branch redirection only acts in RUN; a pending stall ignores the EX stage entirely
  assign flush_now = (state == RUN) & branch_taken;
  assign stall_now = (state == STALL) | (load_use & ~branch_taken);
  always_comb begin
    pc_write      = reset_n & ~stall_now;
    if_id_write   = reset_n & ~stall_now;
    if_id_flush   = ~reset_n | flush_now;
    id_ex_flush   = ~reset_n | flush_now | stall_now;
    pc_sel_branch = reset_n & flush_now;
  end
  always_comb begin
    state_nx = state;
    left_nx  = stall_left;
    if (state == STALL) begin
      left_nx  = stall_left - 2'd1;
      state_nx = stall_left == 2'd1 ? RUN : STALL;
    end else if (stall_now && LOAD_LAT > 1) begin
      state_nx = STALL;
      left_nx  = LEFT_INIT;
    end
  end
  always_ff @(posedge clock or negedge reset_n)
    if (!reset_n) begin
      state      <= RUN;
      stall_left <= '0;
    end else begin
      state      <= state_nx;
      stall_left <= left_nx;
    end
  hazard_cnt16 u_stall_cnt (
    .clock  (clock),
    .reset_n(reset_n),
    .clr    (cnt_clr),
    .inc    (stall_now),
    .count  (stall_cycles)
  );
  hazard_cnt16 u_flush_cnt (
    .clock  (clock),
    .reset_n(reset_n),
    .clr    (cnt_clr),
    .inc    (flush_now),
    .count  (flush_events)
  );
endmodule

// File: tb/tb_hazard_unit.sv
// tb_hazard_unit: scoreboard bench driving LOAD_LAT=1 and LOAD_LAT=3 instances with the same stimulus
module tb_hazard_unit;
  typedef struct {
    logic rn, clr, urs, urt, memr, regw, brz, brn, j, zero, neg;
    logic [5:0] rs, rt, rd;
  } stim_t;
  typedef struct {
    logic [4:0] c[2];
    int s[2];
    int f[2];
  } exp_t;
  logic clock, reset_n, id_uses_rs, id_uses_rt, ex_memr, ex_regw, ex_brz, ex_brn, ex_j, ex_zero, ex_neg, cnt_clr;
  logic [5:0] id_rs, id_rt, ex_rd;
  logic pw1, iw1, iff1, ief1, ps1, pw3, iw3, iff3, ief3, ps3;
  logic [15:0] sc1, fe1, sc3, fe3;
  exp_t q[$];
  int total = 0, bad = 0;
  int busy[2], scnt[2], fcnt[2];
  int lat[2] = '{1, 3};
  stim_t idle;

  hazard_unit #(.LOAD_LAT(1)) u1 (
    .clock(clock), .reset_n(reset_n), .id_rs(id_rs), .id_rt(id_rt),
    .id_uses_rs(id_uses_rs), .id_uses_rt(id_uses_rt), .ex_rd(ex_rd),
    .ex_memr(ex_memr), .ex_regw(ex_regw), .ex_brz(ex_brz), .ex_brn(ex_brn), .ex_j(ex_j),
    .ex_zero(ex_zero), .ex_neg(ex_neg), .cnt_clr(cnt_clr),
    .pc_write(pw1), .if_id_write(iw1), .if_id_flush(iff1), .id_ex_flush(ief1),
    .pc_sel_branch(ps1), .stall_cycles(sc1), .flush_events(fe1));
  hazard_unit #(.LOAD_LAT(3)) u3 (
    .clock(clock), .reset_n(reset_n), .id_rs(id_rs), .id_rt(id_rt),
    .id_uses_rs(id_uses_rs), .id_uses_rt(id_uses_rt), .ex_rd(ex_rd),
    .ex_memr(ex_memr), .ex_regw(ex_regw), .ex_brz(ex_brz), .ex_brn(ex_brn), .ex_j(ex_j),
    .ex_zero(ex_zero), .ex_neg(ex_neg), .cnt_clr(cnt_clr),
    .pc_write(pw3), .if_id_write(iw3), .if_id_flush(iff3), .id_ex_flush(ief3),
    .pc_sel_branch(ps3), .stall_cycles(sc3), .flush_events(fe3));

  initial clock = 0;
  always #5 clock = ~clock;

  // reference: outputs as {pc_write, if_id_write, if_id_flush, id_ex_flush, pc_sel_branch}
  task automatic model(input int k, input stim_t s, output logic [4:0] c, output int so, output int fo);
    bit bt, lu, inc_s, inc_f;
    if (!s.rn) begin
      busy[k] = 0; scnt[k] = 0; fcnt[k] = 0;
      c = 5'b00110; so = 0; fo = 0;
      return;
    end
    so = scnt[k]; fo = fcnt[k];
    bt = (s.brz && s.zero) || (s.brn && s.neg) || s.j;
    lu = s.memr && s.regw && ((s.urs && s.rs == s.rd) || (s.urt && s.rt == s.rd));
    inc_s = 0; inc_f = 0;
    if (busy[k] > 0) begin c = 5'b00010; inc_s = 1; busy[k]--; end
    else if (bt) begin c = 5'b11111; inc_f = 1; end
    else if (lu) begin c = 5'b00010; inc_s = 1; busy[k] = lat[k] - 1; end
    else c = 5'b11000;
    scnt[k] = s.clr ? 0 : (inc_s && scnt[k] < 65535) ? scnt[k] + 1 : scnt[k];
    fcnt[k] = s.clr ? 0 : (inc_f && fcnt[k] < 65535) ? fcnt[k] + 1 : fcnt[k];
  endtask

  task automatic step(input stim_t s);
    exp_t e;
    @(posedge clock);
    #1;
    reset_n = s.rn; cnt_clr = s.clr; id_uses_rs = s.urs; id_uses_rt = s.urt;
    ex_memr = s.memr; ex_regw = s.regw; ex_brz = s.brz; ex_brn = s.brn; ex_j = s.j;
    ex_zero = s.zero; ex_neg = s.neg; id_rs = s.rs; id_rt = s.rt; ex_rd = s.rd;
    for (int k = 0; k < 2; k++) model(k, s, e.c[k], e.s[k], e.f[k]);
    q.push_back(e);
  endtask

  task automatic chk(input string nm, input int act, input int exp);
    total++;
    if (act != exp) begin
      bad++;
      $display("FAIL %s: got %0h expected %0h at %0t", nm, act, exp, $time);
    end
  endtask

  initial begin : monitor
    exp_t e;
    forever begin
      @(negedge clock);
      if (q.size() > 0) begin
        e = q.pop_front();
        chk("ctrl_lat1", int'({pw1, iw1, iff1, ief1, ps1}), int'(e.c[0]));
        chk("stall_cnt_lat1", int'(sc1), e.s[0]);
        chk("flush_cnt_lat1", int'(fe1), e.f[0]);
        chk("ctrl_lat3", int'({pw3, iw3, iff3, ief3, ps3}), int'(e.c[1]));
        chk("stall_cnt_lat3", int'(sc3), e.s[1]);
        chk("flush_cnt_lat3", int'(fe3), e.f[1]);
      end
    end
  end

  initial begin : driver
    stim_t s;
    idle = '{rn: 1'b1, default: '0};
    reset_n = 0; cnt_clr = 0; id_uses_rs = 0; id_uses_rt = 0; ex_memr = 0; ex_regw = 0;
    ex_brz = 0; ex_brn = 0; ex_j = 0; ex_zero = 0; ex_neg = 0; id_rs = 0; id_rt = 0; ex_rd = 0;
    s = idle; s.rn = 0;
    repeat (2) step(s);
    repeat (2) step(idle);
    // load-use on rs: one stall at latency 1, three at latency 3
    s = idle; s.memr = 1; s.regw = 1; s.rd = 5; s.rs = 5; s.urs = 1;
    step(s);
    repeat (4) step(idle);
    // rt matches but is not read: no hazard
    s = idle; s.memr = 1; s.regw = 1; s.rd = 7; s.rt = 7;
    step(s);
    // branch taken with simultaneous load-use: branch wins
    s = idle; s.clr = 1;
    step(s);
    s = idle; s.brz = 1; s.zero = 1; s.memr = 1; s.regw = 1; s.rd = 5; s.rs = 5; s.urs = 1;
    step(s);
    step(idle);
    // reset asserted during the second stall cycle of the latency-3 instance
    s = idle; s.memr = 1; s.regw = 1; s.rd = 9; s.rt = 9; s.urt = 1;
    step(s);
    s = idle; s.rn = 0;
    repeat (2) step(s);
    repeat (2) step(idle);
    for (int i = 0; i < 400; i++) begin
      s.rn = ($urandom_range(0, 49) != 0); s.clr = ($urandom_range(0, 19) == 0);
      s.urs = 1'($urandom); s.urt = 1'($urandom); s.memr = 1'($urandom); s.regw = 1'($urandom);
      s.brz = ($urandom_range(0, 3) == 0); s.brn = ($urandom_range(0, 3) == 0);
      s.j = ($urandom_range(0, 9) == 0); s.zero = 1'($urandom); s.neg = 1'($urandom);
      s.rs = 6'($urandom_range(0, 7)); s.rt = 6'($urandom_range(0, 7)); s.rd = 6'($urandom_range(0, 7));
      step(s);
    end
    // flush counter saturation, then clear wins over a simultaneous increment
    s = idle; s.clr = 1;
    step(s);
    s = idle; s.j = 1;
    repeat (65540) step(s);
    s.clr = 1;
    step(s);
    repeat (3) step(idle);
    repeat (4) @(negedge clock);
    total++;
    if (q.size() != 0) begin
      bad++;
      $display("FAIL drain: %0d entries left, expected 0", q.size());
    end
    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end
endmodule
